// File: rtl/fifo_wptr_full_pkg.sv
// fifo_wptr_full_pkg
// Shared asynchronous-FIFO definitions used by both the write-side and the
// read-side pointer controllers.
//   DEF_ADDR_SIZE   : default memory address width (depth = 2**DEF_ADDR_SIZE)
//   PTR_W_MAX       : widest pointer the helpers handle (Addr_Size 8 -> 9 bits)
//   bin2gray        : binary -> Gray conversion
//   gray2bin        : Gray -> binary conversion
//   gray_full_match : full compare on Gray pointers
// The helpers work at PTR_W_MAX bits. Callers zero-extend narrower pointers
// and truncate the result. Zero upper bits do not affect the low bits of
// either conversion, so one set of functions serves every pointer width.
package fifo_wptr_full_pkg;

  localparam int DEF_ADDR_SIZE = 3;
  localparam int PTR_W_MAX     = 9;

  typedef logic [PTR_W_MAX-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of every Gray bit at or above its position.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin = '0;
    for (int i = 0; i < PTR_W_MAX; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

  // The FIFO is full when the write pointer has lapped the read pointer
  // exactly once. In binary this means the MSB differs and the other bits are
  // equal. In Gray code it means the top two bits are inverted and the rest
  // are equal. ptr_w is the real pointer width (Addr_Size + 1).
  function automatic logic gray_full_match(input ptr_max_t w_gray,
                                           input ptr_max_t r_gray,
                                           input int       ptr_w);
    ptr_max_t top2;
    top2 = ptr_max_t'(3) << (ptr_w - 2);
    return w_gray == (r_gray ^ top2);
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// fifo_wptr_full_if
// Bundles the write-side FIFO signals.
//   master : write requester / read-domain side
//            drives W_INC, W_Ovf_Clr and R_Ptr_Gray
//   slave  : fifo_wptr_full
//            drives W_Addr, W_Ptr_Gray, FIFO_Full, W_Level,
//            W_Almost_Full and W_Overflow
// Addr_Size must match the Addr_Size of the attached fifo_wptr_full.
interface fifo_wptr_full_if
  import fifo_wptr_full_pkg::*;
#(
  parameter int Addr_Size = DEF_ADDR_SIZE
) ();

  logic                 W_INC;
  logic                 W_Ovf_Clr;
  logic [Addr_Size:0]   R_Ptr_Gray;
  logic [Addr_Size-1:0] W_Addr;
  logic [Addr_Size:0]   W_Ptr_Gray;
  logic                 FIFO_Full;
  logic [Addr_Size:0]   W_Level;
  logic                 W_Almost_Full;
  logic                 W_Overflow;

  modport master (
    output W_INC, W_Ovf_Clr, R_Ptr_Gray,
    input  W_Addr, W_Ptr_Gray, FIFO_Full, W_Level, W_Almost_Full, W_Overflow
  );

  modport slave (
    input  W_INC, W_Ovf_Clr, R_Ptr_Gray,
    output W_Addr, W_Ptr_Gray, FIFO_Full, W_Level, W_Almost_Full, W_Overflow
  );

endinterface

// File: rtl/fifo_sync_2ff.sv
// fifo_sync_2ff
// Two-flop synchronizer for a Gray-coded pointer crossing into the CLK
// domain. The input must change at most one bit per source update. No logic
// sits between the two flops.
//   CLK : destination clock
//   RST : asynchronous, active-low reset
//   D   : pointer from the other clock domain
//   Q   : synchronized pointer
module fifo_sync_2ff #(
  parameter int Width = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [Width-1:0] D,
  output logic [Width-1:0] Q
);

  logic [Width-1:0] q1_reg;
  logic [Width-1:0] q2_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q1_reg <= '0;
      q2_reg <= '0;
    end else begin
      q1_reg <= D;
      q2_reg <= q1_reg;
    end
  end

  assign Q = q2_reg;

endmodule

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full
// Write-domain pointer and full-flag controller for an asynchronous FIFO.
// Runs entirely on W_CLK.
// Ports:
//   W_CLK : write-domain clock
//   W_RST : asynchronous, active-low reset
//   bus   : fifo_wptr_full_if.slave
//     W_INC         (in)  write request; accepted only while FIFO_Full is 0
//     W_Ovf_Clr     (in)  synchronous clear of W_Overflow
//     R_Ptr_Gray    (in)  Gray read pointer from the read domain
//     W_Addr        (out) binary write address to the memory
//     W_Ptr_Gray    (out) registered Gray write pointer to the read domain
//     FIFO_Full     (out) registered full flag
//     W_Level       (out) entries in use as seen here; may over-report,
//                         never under-reports
//     W_Almost_Full (out) W_Level >= AF_Thr
//     W_Overflow    (out) sticky; set by a write attempt while full
// Build option:
//   FIFO_ALMOST_FULL_EN : when defined, builds the W_Almost_Full register.
//                         When undefined, W_Almost_Full is tied to 0.
module fifo_wptr_full
  import fifo_wptr_full_pkg::*;
#(
  parameter int Addr_Size = DEF_ADDR_SIZE,
  parameter int AF_Thr    = 6
) (
  input  logic             W_CLK,
  input  logic             W_RST,
  fifo_wptr_full_if.slave  bus
);

  localparam int PtrW = Addr_Size + 1;

  // Reject out-of-range configurations at elaboration time.
  if (Addr_Size < 2 || Addr_Size > 8 || AF_Thr < 1 || AF_Thr > (1 << Addr_Size)) begin : g_bad_param
    $error("fifo_wptr_full: Addr_Size must be 2..8 and AF_Thr 1..2**Addr_Size");
  end

  logic [Addr_Size:0] w_bin_reg;
  logic [Addr_Size:0] w_bin_next;
  logic [Addr_Size:0] w_gray_reg;
  logic [Addr_Size:0] w_gray_next;
  logic [Addr_Size:0] rq2;
  logic [Addr_Size:0] r_bin;
  logic [Addr_Size:0] w_level_reg;
  logic [Addr_Size:0] w_level_next;
  logic               full_reg;
  logic               full_next;
  logic               ovf_reg;
  logic               wr_acc;

  fifo_sync_2ff #(
    .Width (PtrW)
  ) u_rptr_sync (
    .CLK (W_CLK),
    .RST (W_RST),
    .D   (bus.R_Ptr_Gray),
    .Q   (rq2)
  );

  // Full and level look at the post-write pointer, so FIFO_Full rises on the
  // same edge as the write that fills the last slot. The next request is then
  // blocked. The synchronized read pointer can only lag the real one, so the
  // level can only err on the high side.
  always_comb begin
    wr_acc       = bus.W_INC & ~full_reg;
    w_bin_next   = w_bin_reg + {{Addr_Size{1'b0}}, wr_acc};
    w_gray_next  = PtrW'(bin2gray(PTR_W_MAX'(w_bin_next)));
    r_bin        = PtrW'(gray2bin(PTR_W_MAX'(rq2)));
    w_level_next = w_bin_next - r_bin;
    full_next    = gray_full_match(PTR_W_MAX'(w_gray_next), PTR_W_MAX'(rq2), PtrW);
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      w_bin_reg   <= '0;
      w_gray_reg  <= '0;
      w_level_reg <= '0;
      full_reg    <= 1'b0;
    end else begin
      w_bin_reg   <= w_bin_next;
      w_gray_reg  <= w_gray_next;
      w_level_reg <= w_level_next;
      full_reg    <= full_next;
    end
  end

  // Set has priority over clear, so a write attempt while full is never lost
  // when it lands in the same cycle as a clear.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      ovf_reg <= 1'b0;
    end else if (bus.W_INC && full_reg) begin
      ovf_reg <= 1'b1;
    end else if (bus.W_Ovf_Clr) begin
      ovf_reg <= 1'b0;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  logic af_reg;

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      af_reg <= 1'b0;
    end else begin
      af_reg <= (int'(w_level_next) >= AF_Thr);
    end
  end

  assign bus.W_Almost_Full = af_reg;
`else
  assign bus.W_Almost_Full = 1'b0;
`endif

  // The memory writes at the current address. The pointer advances on the
  // same edge that accepts the write.
  assign bus.W_Addr     = w_bin_reg[Addr_Size-1:0];
  assign bus.W_Ptr_Gray = w_gray_reg;
  assign bus.FIFO_Full  = full_reg;
  assign bus.W_Level    = w_level_reg;
  assign bus.W_Overflow = ovf_reg;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full
// Self-checking bench for fifo_wptr_full (Addr_Size = 3, AF_Thr = 6).
// Each driven cycle pushes the expected post-edge outputs from a behavioural
// model onto a scoreboard queue. The entry is popped and compared after the
// clock edge. Directed checks cover reset, full/overflow, release latency and
// pointer wrap. W_Almost_Full expectations follow FIFO_ALMOST_FULL_EN.
module tb_fifo_wptr_full;

  localparam int AS     = 3;
  localparam int AF_THR = 6;

  logic W_CLK = 1'b0;
  logic W_RST = 1'b1;

  always #5 W_CLK = ~W_CLK;

  fifo_wptr_full_if #(.Addr_Size(AS)) bus ();

  fifo_wptr_full #(
    .Addr_Size (AS),
    .AF_Thr    (AF_THR)
  ) dut (
    .W_CLK (W_CLK),
    .W_RST (W_RST),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] addr;
    logic [3:0] gray;
    logic       full;
    logic [3:0] level;
    logic       af;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state.
  int         m_w;
  logic [3:0] m_rq1, m_rq2;
  logic       m_full, m_ovf;
  logic       m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [3:0] b2g(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ {1'b0, x[3:1]};
  endfunction

  task automatic model_reset();
    m_w    = 0;
    m_rq1  = '0;
    m_rq2  = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    m_acc  = 1'b0;
    sb_q.delete();
  endtask

  // One W_CLK cycle: drive at negedge, model, then pop and compare after the edge.
  task automatic cycle(input logic inc, input logic clr, input logic [3:0] rg);
    exp_t e;
    exp_t x;
    int   w_n;
    logic [3:0] lvl_n;
    @(negedge W_CLK);
    bus.W_INC      = inc;
    bus.W_Ovf_Clr  = clr;
    bus.R_Ptr_Gray = rg;
    m_acc  = inc && !m_full;
    w_n    = (m_w + (m_acc ? 1 : 0)) % 16;
    lvl_n  = 4'((w_n - int'(g2b(m_rq2))) & 15);
    e.addr  = 3'(w_n % 8);
    e.gray  = b2g(w_n);
    e.level = lvl_n;
    e.full  = (lvl_n == 4'd8);
    e.ovf   = (inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
`ifdef FIFO_ALMOST_FULL_EN
    e.af    = (int'(lvl_n) >= AF_THR);
`else
    e.af    = 1'b0;
`endif
    m_w    = w_n;
    m_full = e.full;
    m_ovf  = e.ovf;
    m_rq2  = m_rq1;
    m_rq1  = rg;
    sb_q.push_back(e);
    @(posedge W_CLK);
    #1;
    x = sb_q.pop_front();
    $display("txn inc=%0b clr=%0b rptr=%b -> addr=%0d gray=%b full=%b lvl=%0d af=%b ovf=%b",
             inc, clr, rg, bus.W_Addr, bus.W_Ptr_Gray, bus.FIFO_Full, bus.W_Level,
             bus.W_Almost_Full, bus.W_Overflow);
    chk("addr",  32'(bus.W_Addr),        32'(x.addr));
    chk("gray",  32'(bus.W_Ptr_Gray),    32'(x.gray));
    chk("full",  32'(bus.FIFO_Full),     32'(x.full));
    chk("level", 32'(bus.W_Level),       32'(x.level));
    chk("af",    32'(bus.W_Almost_Full), 32'(x.af));
    chk("ovf",   32'(bus.W_Overflow),    32'(x.ovf));
  endtask

  // Asynchronous reset, asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge W_CLK);
    #2;
    W_RST          = 1'b0;
    bus.W_INC      = 1'b0;
    bus.W_Ovf_Clr  = 1'b0;
    bus.R_Ptr_Gray = '0;
    #1;
    $display("txn reset asserted -> addr=%0d gray=%b full=%b lvl=%0d af=%b ovf=%b",
             bus.W_Addr, bus.W_Ptr_Gray, bus.FIFO_Full, bus.W_Level,
             bus.W_Almost_Full, bus.W_Overflow);
    chk("rst_addr",  32'(bus.W_Addr),        32'd0);
    chk("rst_gray",  32'(bus.W_Ptr_Gray),    32'd0);
    chk("rst_full",  32'(bus.FIFO_Full),     32'd0);
    chk("rst_level", 32'(bus.W_Level),       32'd0);
    chk("rst_af",    32'(bus.W_Almost_Full), 32'd0);
    chk("rst_ovf",   32'(bus.W_Overflow),    32'd0);
    model_reset();
    @(negedge W_CLK);
    W_RST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] prev;
    int n;
    bus.W_INC      = 1'b0;
    bus.W_Ovf_Clr  = 1'b0;
    bus.R_Ptr_Gray = '0;
    model_reset();

    do_reset();

    // Reset in the middle of a write stream.
    repeat (5) cycle(1'b1, 1'b0, 4'b0000);
    do_reset();
    cycle(1'b0, 1'b0, 4'b0000);
    chk("addr_after_rst", 32'(bus.W_Addr), 32'd0);

    // Fill with the read pointer held at 0.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'b0000);
    chk("fill_full",  32'(bus.FIFO_Full),  32'd1);
    chk("fill_level", 32'(bus.W_Level),    32'd8);
    chk("fill_gray",  32'(bus.W_Ptr_Gray), 32'b1100);

    // Overflow while full; set beats clear.
    repeat (3) cycle(1'b1, 1'b0, 4'b0000);
    chk("ovf_set",   32'(bus.W_Overflow), 32'd1);
    chk("ovf_addr",  32'(bus.W_Addr),     32'd0);
    chk("ovf_level", 32'(bus.W_Level),    32'd8);
    repeat (2) cycle(1'b0, 1'b0, 4'b0000);
    chk("ovf_sticky", 32'(bus.W_Overflow), 32'd1);
    cycle(1'b1, 1'b1, 4'b0000);
    chk("ovf_set_wins", 32'(bus.W_Overflow), 32'd1);
    cycle(1'b0, 1'b1, 4'b0000);
    chk("ovf_clr", 32'(bus.W_Overflow), 32'd0);

    // Release: read pointer moves to 2; full drops on the third edge.
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 4'b0011);
      n++;
    end while (bus.FIFO_Full && n < 10);
    chk("rel_latency", 32'(n), 32'd3);
    chk("rel_level", 32'(bus.W_Level), 32'd6);
    cycle(1'b1, 1'b0, 4'b0011);
    cycle(1'b1, 1'b0, 4'b0011);
    chk("refill_full", 32'(bus.FIFO_Full), 32'd1);

    // Read pointer to 5: level 5, almost-full falls when enabled.
    repeat (3) cycle(1'b0, 1'b0, 4'b0111);
    chk("af_fall_level", 32'(bus.W_Level), 32'd5);
    chk("af_fall", 32'(bus.W_Almost_Full), 32'd0);

    // Wrap-around with a read pointer lagging three writes behind.
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      prev = bus.W_Ptr_Gray;
      cycle(1'b1, 1'b0, b2g(i > 3 ? i - 3 : 0));
      chk("gray_one_bit", 32'($countones(prev ^ bus.W_Ptr_Gray)), 32'd1);
      chk("no_false_full", 32'(bus.FIFO_Full), 32'd0);
      if (i == 8 || i == 16) chk("msb_toggle", 32'(prev[3] ^ bus.W_Ptr_Gray[3]), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
